axi_aw_router: RTL and testbench

- Parameterised successor of the fixed 3-master/7-slave write-address channel. Arbitrates NUM_M masters onto NUM_S slaves.
- Uses round-robin arbitration with a registered AW output stage and a parameter-driven address map.
- Holds the route (master, slave) from AW acceptance until the B handshake, so the W and B muxes in the interconnect top can steer by it.
- Addresses that hit no slave are claimed internally as decode errors (DECERR); no slave sees them.

---
 rtl/axi_aw_router_pkg.sv | 40 ++++
 rtl/axi_aw_router_if.sv | 45 ++++
 rtl/axi_aw_router_rr_arbiter.sv | 50 +++++
 rtl/axi_aw_router.sv | 195 +++++++++++++++++++
 tb/tb_axi_aw_router.sv | 361 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_aw_router_pkg.sv
// Shared types and helpers for the AXI address-channel routers.
// Holds the route FSM states, the DECERR code and the address-map decoder.
package axi_rt_pkg;

    localparam int AXI_ADDR_W = 32;
    localparam int AXI_ID_W   = 4;

    // The decoder works on the widest supported map; callers zero-extend into it.
    localparam int MAX_S      = 16;
    localparam int MAX_ADDR_W = 64;
    localparam int DEC_W      = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        AW   = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } rt_state_e;

    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Lowest matching slot wins; no match returns num_s (the DECERR index).
    function automatic logic [DEC_W-1:0] addr_decode(
        input logic [MAX_ADDR_W-1:0]       addr,
        input logic [MAX_S*MAX_ADDR_W-1:0] s_base,
        input logic [MAX_S*MAX_ADDR_W-1:0] s_mask,
        input int                          num_s
    );
        logic [DEC_W-1:0] hit;
        hit = DEC_W'(num_s);
        for (int i = MAX_S - 1; i >= 0; i--) begin
            if ((i < num_s) &&
                ((addr & s_mask[i*MAX_ADDR_W +: MAX_ADDR_W]) == s_base[i*MAX_ADDR_W +: MAX_ADDR_W])) begin
                hit = DEC_W'(i);
            end
        end
        return hit;
    endfunction

endpackage

// File: rtl/axi_aw_router_if.sv
// Write-address bundle between NUM_M masters, the router and NUM_S slaves.
// 'slave' is the router's view; 'master' is the view of the surrounding fabric.
interface axi_aw_router_if #(
    parameter int NUM_M  = 3,
    parameter int NUM_S  = 7,
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 4,
    parameter int SIZE_W = 3
);
    localparam int MW = ($clog2(NUM_M) > 1) ? $clog2(NUM_M) : 1;

    // Handshake: a beat transfers on the cycle where valid and ready are both 1;
    // valid never waits on ready, and payload stays stable while valid is held.
    logic [NUM_M*ID_W-1:0]   m_awid;
    logic [NUM_M*ADDR_W-1:0] m_awaddr;
    logic [NUM_M*LEN_W-1:0]  m_awlen;
    logic [NUM_M*SIZE_W-1:0] m_awsize;
    logic [NUM_M*2-1:0]      m_awburst;
    logic [NUM_M-1:0]        m_awvalid;
    logic [NUM_M-1:0]        m_awready;

    logic [MW+ID_W-1:0]      s_awid;
    logic [ADDR_W-1:0]       s_awaddr;
    logic [LEN_W-1:0]        s_awlen;
    logic [SIZE_W-1:0]       s_awsize;
    logic [1:0]              s_awburst;
    logic [NUM_S-1:0]        s_awvalid;
    logic [NUM_S-1:0]        s_awready;

    modport slave (
        input  m_awid, m_awaddr, m_awlen, m_awsize, m_awburst, m_awvalid,
        output m_awready,
        output s_awid, s_awaddr, s_awlen, s_awsize, s_awburst, s_awvalid,
        input  s_awready
    );

    modport master (
        output m_awid, m_awaddr, m_awlen, m_awsize, m_awburst, m_awvalid,
        input  m_awready,
        input  s_awid, s_awaddr, s_awlen, s_awsize, s_awburst, s_awvalid,
        output s_awready
    );

endinterface

// File: rtl/axi_aw_router_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer.
// The pointer moves past the winner only when the caller strobes adv.
module rr_arbiter #(
    parameter  int N  = 3,
    localparam int IW = ($clog2(N) > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          adv,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_any
);

    logic [IW-1:0] ptr_q;
    logic [IW-1:0] ptr_d;

    always_comb begin
        int j;
        j       = 0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr_q) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (!gnt_any && req[j]) begin
                gnt_any = 1'b1;
                gnt_idx = IW'(j);
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (adv && gnt_any) begin
            ptr_d = (int'(gnt_idx) == N - 1) ? '0 : gnt_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/axi_aw_router.sv
// Write-address router: round-robin over NUM_M masters, registered AW stage,
// address-map decode to NUM_S slaves, and a held route from AW acceptance to B.
module axi_aw_router
    import axi_rt_pkg::*;
#(
    parameter  int NUM_M  = 3,
    parameter  int NUM_S  = 7,
    parameter  int ID_W   = AXI_ID_W,
    parameter  int ADDR_W = AXI_ADDR_W,
    parameter  int LEN_W  = 4,
    parameter  int SIZE_W = 3,
    parameter  logic [NUM_S*ADDR_W-1:0] S_BASE = {32'h0006_0000, 32'h0005_0000, 32'h0004_0000,
                                                  32'h0003_0000, 32'h0002_0000, 32'h0001_0000,
                                                  32'h0000_0000},
    parameter  logic [NUM_S*ADDR_W-1:0] S_MASK = {7{32'hFFFF_0000}},
    localparam int MW = ($clog2(NUM_M) > 1) ? $clog2(NUM_M) : 1,
    localparam int SW = $clog2(NUM_S + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    axi_aw_router_if.slave        bus,
    input  logic                  w_last_hs,
    input  logic                  b_hs,
    output logic                  route_valid,
    output logic [MW-1:0]         route_m,
    output logic [SW-1:0]         route_s,
    output logic                  decerr,
    output rt_state_e             dbg_state_o
);

    rt_state_e             state_q, state_d;
    logic [MW+ID_W-1:0]    awid_q, awid_d;
    logic [ADDR_W-1:0]     awaddr_q, awaddr_d;
    logic [LEN_W-1:0]      awlen_q, awlen_d;
    logic [SIZE_W-1:0]     awsize_q, awsize_d;
    logic [1:0]            awburst_q, awburst_d;
    logic [NUM_S-1:0]      s_awvalid_q, s_awvalid_d;
    logic [MW-1:0]         route_m_q, route_m_d;
    logic [SW-1:0]         route_s_q, route_s_d;
    logic                  decerr_q, decerr_d;
    logic                  wlast_q, wlast_d;

    logic                  grant_adv;
    logic [MW-1:0]         gnt_idx;
    logic                  gnt_any;
    logic [NUM_M-1:0]      awready_c;

    logic [ID_W-1:0]       sel_id;
    logic [ADDR_W-1:0]     sel_addr;
    logic [LEN_W-1:0]      sel_len;
    logic [SIZE_W-1:0]     sel_size;
    logic [1:0]            sel_burst;

    logic [MAX_S*MAX_ADDR_W-1:0] base_ext, mask_ext;
    logic [DEC_W-1:0]      dec_raw;
    logic [SW-1:0]         dec_s;
    logic                  dec_hit;

    // Requests are only visible to the arbiter while no burst is open.
    rr_arbiter #(.N(NUM_M)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (bus.m_awvalid & {NUM_M{state_q == IDLE}}),
        .adv     (grant_adv),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    assign sel_id    = bus.m_awid[gnt_idx*ID_W +: ID_W];
    assign sel_addr  = bus.m_awaddr[gnt_idx*ADDR_W +: ADDR_W];
    assign sel_len   = bus.m_awlen[gnt_idx*LEN_W +: LEN_W];
    assign sel_size  = bus.m_awsize[gnt_idx*SIZE_W +: SIZE_W];
    assign sel_burst = bus.m_awburst[gnt_idx*2 +: 2];

    always_comb begin
        base_ext = '0;
        mask_ext = '0;
        for (int i = 0; i < NUM_S; i++) begin
            base_ext[i*MAX_ADDR_W +: MAX_ADDR_W] = MAX_ADDR_W'(S_BASE[i*ADDR_W +: ADDR_W]);
            mask_ext[i*MAX_ADDR_W +: MAX_ADDR_W] = MAX_ADDR_W'(S_MASK[i*ADDR_W +: ADDR_W]);
        end
    end

    assign dec_raw = addr_decode(MAX_ADDR_W'(sel_addr), base_ext, mask_ext, NUM_S);
    assign dec_hit = (dec_raw != DEC_W'(NUM_S));
    assign dec_s   = SW'(dec_raw);

    always_comb begin
        state_d     = state_q;
        awid_d      = awid_q;
        awaddr_d    = awaddr_q;
        awlen_d     = awlen_q;
        awsize_d    = awsize_q;
        awburst_d   = awburst_q;
        s_awvalid_d = s_awvalid_q;
        route_m_d   = route_m_q;
        route_s_d   = route_s_q;
        decerr_d    = decerr_q;
        wlast_d     = wlast_q;
        grant_adv   = 1'b0;
        awready_c   = '0;

        case (state_q)
            IDLE: begin
                if (gnt_any) begin
                    grant_adv = 1'b1;
                    awready_c = NUM_M'(1) << gnt_idx;
                    awid_d    = {gnt_idx, sel_id};
                    awaddr_d  = sel_addr;
                    awlen_d   = sel_len;
                    awsize_d  = sel_size;
                    awburst_d = sel_burst;
                    route_m_d = gnt_idx;
                    route_s_d = dec_s;
                    wlast_d   = 1'b0;
                    if (dec_hit) begin
                        s_awvalid_d = NUM_S'(1) << dec_s;
                        decerr_d    = 1'b0;
                        state_d     = AW;
                    end else begin
                        s_awvalid_d = '0;
                        decerr_d    = 1'b1;
                        state_d     = DATA;
                    end
                end
            end
            AW: begin
                // WLAST may beat the AW handshake; remember it so DATA is skipped.
                if (w_last_hs) begin
                    wlast_d = 1'b1;
                end
                if (|(s_awvalid_q & bus.s_awready)) begin
                    s_awvalid_d = '0;
                    state_d     = (wlast_q || w_last_hs) ? RESP : DATA;
                end
            end
            DATA: begin
                if (w_last_hs) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (b_hs) begin
                    decerr_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            awid_q      <= '0;
            awaddr_q    <= '0;
            awlen_q     <= '0;
            awsize_q    <= '0;
            awburst_q   <= '0;
            s_awvalid_q <= '0;
            route_m_q   <= '0;
            route_s_q   <= '0;
            decerr_q    <= 1'b0;
            wlast_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            awid_q      <= awid_d;
            awaddr_q    <= awaddr_d;
            awlen_q     <= awlen_d;
            awsize_q    <= awsize_d;
            awburst_q   <= awburst_d;
            s_awvalid_q <= s_awvalid_d;
            route_m_q   <= route_m_d;
            route_s_q   <= route_s_d;
            decerr_q    <= decerr_d;
            wlast_q     <= wlast_d;
        end
    end

    // AWREADY is combinational from the grant, so it must also drop with reset.
    assign bus.m_awready = rst ? '0 : awready_c;
    assign bus.s_awid    = awid_q;
    assign bus.s_awaddr  = awaddr_q;
    assign bus.s_awlen   = awlen_q;
    assign bus.s_awsize  = awsize_q;
    assign bus.s_awburst = awburst_q;
    assign bus.s_awvalid = s_awvalid_q;

    assign route_valid   = (state_q != IDLE);
    assign route_m       = route_m_q;
    assign route_s       = route_s_q;
    assign decerr        = decerr_q;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_axi_aw_router.sv
// Directed bench for axi_aw_router: scoreboard queues for routes and AW beats,
// plus a second small elaboration with two masters and one slave.
module tb_axi_aw_router;
    import axi_rt_pkg::*;

    logic clk = 1'b0;
    logic rst, rst2;
    logic w_last_hs, b_hs, w_last2, b_hs2;

    logic        route_valid, decerr;
    logic [1:0]  route_m;
    logic [2:0]  route_s;
    rt_state_e   dbg_state;

    logic        route_valid2, decerr2;
    logic [0:0]  route_m2;
    logic [0:0]  route_s2;
    rt_state_e   dbg_state2;

    int checks = 0;
    int errors = 0;

    logic [5:0]  route_q[$];
    logic [53:0] aw_q[$];
    logic [5:0]  exp_route;
    logic [53:0] exp_aw;
    logic        rv_prev = 1'b0;

    always #5 clk = ~clk;

    axi_aw_router_if #(.NUM_M(3), .NUM_S(7)) bus ();
    axi_aw_router_if #(.NUM_M(2), .NUM_S(1)) bus2 ();

    axi_aw_router #(
        .NUM_M (3),
        .NUM_S (7),
        .S_BASE({32'h0006_0000, 32'h0005_0000, 32'h0004_0000, 32'h0003_0000,
                 32'h0002_0000, 32'h0001_0000, 32'h0000_0000}),
        .S_MASK({7{32'hFFFF_0000}})
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .w_last_hs   (w_last_hs),
        .b_hs        (b_hs),
        .route_valid (route_valid),
        .route_m     (route_m),
        .route_s     (route_s),
        .decerr      (decerr),
        .dbg_state_o (dbg_state)
    );

    axi_aw_router #(
        .NUM_M (2),
        .NUM_S (1),
        .S_BASE(32'h1000_0000),
        .S_MASK(32'hF000_0000)
    ) dut2 (
        .clk         (clk),
        .rst         (rst2),
        .bus         (bus2),
        .w_last_hs   (w_last2),
        .b_hs        (b_hs2),
        .route_valid (route_valid2),
        .route_m     (route_m2),
        .route_s     (route_s2),
        .decerr      (decerr2),
        .dbg_state_o (dbg_state2)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [53:0] mk_aw(input logic [6:0] oh, input logic [1:0] g,
                                          input logic [3:0] id, input logic [31:0] a,
                                          input logic [3:0] l, input logic [2:0] s,
                                          input logic [1:0] b);
        return {oh, g, id, a, l, s, b};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_m(input int m, input logic [3:0] id, input logic [31:0] a,
                         input logic [3:0] l, input logic [2:0] s, input logic [1:0] b);
        bus.m_awid[m*4 +: 4]    = id;
        bus.m_awaddr[m*32 +: 32] = a;
        bus.m_awlen[m*4 +: 4]   = l;
        bus.m_awsize[m*3 +: 3]  = s;
        bus.m_awburst[m*2 +: 2] = b;
    endtask

    // Waits (bounded) until a route opens, then realigns to just after a rising edge.
    task automatic wait_route(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!route_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!route_valid) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: route_valid=0 expected 1", name);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic finish_burst(input bit is_dec);
        if (!is_dec) begin
            bus.s_awready = '1;
            tick();
            bus.s_awready = '0;
        end
        w_last_hs = 1'b1;
        tick();
        w_last_hs = 1'b0;
        b_hs = 1'b1;
        tick();
        b_hs = 1'b0;
    endtask

    // Monitor: AW handshakes and route openings are popped against the queues.
    always @(negedge clk) begin
        if (!rst) begin
            if (|(bus.s_awvalid & bus.s_awready)) begin
                if (aw_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL aw_unexpected: got valid %b with empty queue", bus.s_awvalid);
                end else begin
                    exp_aw = aw_q.pop_front();
                    chk("aw_fields", {bus.s_awvalid, bus.s_awid, bus.s_awaddr, bus.s_awlen,
                                      bus.s_awsize, bus.s_awburst}, 64'(exp_aw));
                end
            end
            if (route_valid && !rv_prev) begin
                if (route_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL route_unexpected: got m=%0d s=%0d with empty queue", route_m, route_s);
                end else begin
                    exp_route = route_q.pop_front();
                    chk("route", {route_m, route_s, decerr}, 64'(exp_route));
                end
            end
            if (route_valid) begin
                chk("awready_closed", 64'(bus.m_awready), 64'd0);
            end
        end
        rv_prev = route_valid;
    end

    initial begin
        #400000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        rst2 = 1'b1;
        w_last_hs = 1'b0;
        b_hs = 1'b0;
        w_last2 = 1'b0;
        b_hs2 = 1'b0;
        bus.s_awready = '0;
        bus2.s_awready = '0;
        bus2.m_awvalid = '0;
        bus2.m_awid = '0;
        bus2.m_awaddr = '0;
        bus2.m_awlen = '0;
        bus2.m_awsize = '0;
        bus2.m_awburst = '0;
        set_m(0, 4'hA, 32'h0000_0010, 4'd1, 3'd2, 2'd1);
        set_m(1, 4'h5, 32'h0001_0020, 4'd0, 3'd2, 2'd1);
        set_m(2, 4'hC, 32'h0005_0030, 4'd7, 3'd3, 2'd2);
        bus.m_awvalid = 3'b111;

        // Reset state, with every master already requesting
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_awready", 64'(bus.m_awready), 64'd0);
        chk("rst_s_awvalid", 64'(bus.s_awvalid), 64'd0);
        chk("rst_route_valid", 64'(route_valid), 64'd0);
        chk("rst_decerr", 64'(decerr), 64'd0);
        chk("rst_route_m", 64'(route_m), 64'd0);
        chk("rst_route_s", 64'(route_s), 64'd0);
        chk("rst_s_awid", 64'(bus.s_awid), 64'd0);
        chk("rst_state", 64'(dbg_state), 64'(IDLE));

        // Round robin 0,1,2,0 with requests held
        route_q.push_back({2'd0, 3'd0, 1'b0});
        route_q.push_back({2'd1, 3'd1, 1'b0});
        route_q.push_back({2'd2, 3'd5, 1'b0});
        route_q.push_back({2'd0, 3'd0, 1'b0});
        aw_q.push_back(mk_aw(7'b0000001, 2'd0, 4'hA, 32'h0000_0010, 4'd1, 3'd2, 2'd1));
        aw_q.push_back(mk_aw(7'b0000010, 2'd1, 4'h5, 32'h0001_0020, 4'd0, 3'd2, 2'd1));
        aw_q.push_back(mk_aw(7'b0100000, 2'd2, 4'hC, 32'h0005_0030, 4'd7, 3'd3, 2'd2));
        aw_q.push_back(mk_aw(7'b0000001, 2'd0, 4'hA, 32'h0000_0010, 4'd1, 3'd2, 2'd1));
        @(posedge clk);
        #1 rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            wait_route("rr");
            if (k == 3) bus.m_awvalid = '0;
            finish_burst(1'b0);
        end

        // Master 1 to slave 3, slave stalls AWREADY for four cycles
        set_m(1, 4'h9, 32'h0003_1234, 4'd3, 3'd2, 2'd1);
        route_q.push_back({2'd1, 3'd3, 1'b0});
        aw_q.push_back(mk_aw(7'b0001000, 2'd1, 4'h9, 32'h0003_1234, 4'd3, 3'd2, 2'd1));
        bus.m_awvalid = 3'b010;
        wait_route("stall");
        bus.m_awvalid = '0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("stall_valid", 64'(bus.s_awvalid), 64'h08);
            chk("stall_addr", 64'(bus.s_awaddr), 64'h0003_1234);
            chk("stall_id", 64'(bus.s_awid), 64'h19);
            chk("stall_len", 64'(bus.s_awlen), 64'd3);
            chk("stall_route_s", 64'(route_s), 64'd3);
            @(posedge clk);
            #1;
        end
        finish_burst(1'b0);

        // Unmapped address from master 2 is a decode error
        set_m(2, 4'h2, 32'h0008_0000, 4'd0, 3'd2, 2'd1);
        route_q.push_back({2'd2, 3'd7, 1'b1});
        bus.m_awvalid = 3'b100;
        wait_route("decerr");
        bus.m_awvalid = '0;
        @(negedge clk);
        chk("dec_s_awvalid", 64'(bus.s_awvalid), 64'd0);
        chk("dec_flag", 64'(decerr), 64'd1);
        chk("dec_state", 64'(dbg_state), 64'(DATA));
        @(posedge clk);
        #1;
        finish_burst(1'b1);
        @(negedge clk);
        chk("dec_back_idle", 64'(dbg_state), 64'(IDLE));
        chk("dec_route_clr", 64'(route_valid), 64'd0);
        chk("dec_flag_clr", 64'(decerr), 64'd0);

        // WLAST in the same cycle as the AW handshake
        set_m(0, 4'h1, 32'h0006_0040, 4'd0, 3'd2, 2'd1);
        route_q.push_back({2'd0, 3'd6, 1'b0});
        aw_q.push_back(mk_aw(7'b1000000, 2'd0, 4'h1, 32'h0006_0040, 4'd0, 3'd2, 2'd1));
        bus.m_awvalid = 3'b001;
        wait_route("wlast");
        bus.m_awvalid = '0;
        bus.s_awready = '1;
        w_last_hs = 1'b1;
        tick();
        bus.s_awready = '0;
        w_last_hs = 1'b0;
        @(negedge clk);
        chk("wl_resp_1", 64'(dbg_state), 64'(RESP));
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("wl_resp_2", 64'(dbg_state), 64'(RESP));
        @(posedge clk);
        #1;
        b_hs = 1'b1;
        tick();
        b_hs = 1'b0;
        @(negedge clk);
        chk("wl_idle", 64'(dbg_state), 64'(IDLE));

        // Asynchronous reset while a burst is open; pointer returns to master 0
        set_m(1, 4'h7, 32'h0002_0000, 4'd0, 3'd2, 2'd1);
        route_q.push_back({2'd1, 3'd2, 1'b0});
        bus.m_awvalid = 3'b010;
        wait_route("rst_mid");
        set_m(0, 4'hA, 32'h0000_0010, 4'd1, 3'd2, 2'd1);
        bus.m_awvalid = 3'b111;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_s_awvalid", 64'(bus.s_awvalid), 64'd0);
        chk("arst_route_valid", 64'(route_valid), 64'd0);
        chk("arst_awready", 64'(bus.m_awready), 64'd0);
        chk("arst_state", 64'(dbg_state), 64'(IDLE));
        route_q.push_back({2'd0, 3'd0, 1'b0});
        aw_q.push_back(mk_aw(7'b0000001, 2'd0, 4'hA, 32'h0000_0010, 4'd1, 3'd2, 2'd1));
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_grant", 64'(bus.m_awready), 64'b001);
        wait_route("post_rst");
        bus.m_awvalid = '0;
        finish_burst(1'b0);
        @(negedge clk);
        chk("route_q_empty", 64'(route_q.size()), 64'd0);
        chk("aw_q_empty", 64'(aw_q.size()), 64'd0);

        // Two masters, one slave: round robin and DECERR with a 1-bit route_m
        bus2.m_awid    = {4'h6, 4'h3};
        bus2.m_awaddr  = {32'h2000_0000, 32'h1000_0004};
        bus2.m_awlen   = {4'd0, 4'd2};
        bus2.m_awsize  = {3'd2, 3'd2};
        bus2.m_awburst = {2'd1, 2'd1};
        bus2.m_awvalid = 2'b11;
        @(posedge clk);
        #1 rst2 = 1'b0;
        @(negedge clk);
        chk("m2_grant0", 64'(bus2.m_awready), 64'b01);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("m2_s_awvalid", 64'(bus2.s_awvalid), 64'd1);
        chk("m2_s_awid", 64'(bus2.s_awid), 64'h03);
        chk("m2_s_awaddr", 64'(bus2.s_awaddr), 64'h1000_0004);
        chk("m2_route", 64'({route_m2, route_s2, decerr2}), 64'b000);
        @(posedge clk);
        #1 bus2.s_awready = 1'b1;
        tick();
        bus2.s_awready = 1'b0;
        w_last2 = 1'b1;
        tick();
        w_last2 = 1'b0;
        b_hs2 = 1'b1;
        tick();
        b_hs2 = 1'b0;
        @(negedge clk);
        chk("m2_grant1", 64'(bus2.m_awready), 64'b10);
        @(posedge clk);
        #1 bus2.m_awvalid = '0;
        @(negedge clk);
        chk("m2_dec_route", 64'({route_m2, route_s2, decerr2}), 64'b111);
        chk("m2_dec_s_awvalid", 64'(bus2.s_awvalid), 64'd0);
        chk("m2_dec_state", 64'(dbg_state2), 64'(DATA));
        @(posedge clk);
        #1 w_last2 = 1'b1;
        tick();
        w_last2 = 1'b0;
        b_hs2 = 1'b1;
        tick();
        b_hs2 = 1'b0;
        @(negedge clk);
        chk("m2_idle", 64'(dbg_state2), 64'(IDLE));
        chk("m2_route_clr", 64'(route_valid2), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
